// File: rtl/search_update_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module   : search_update_scheduler_pkg
// Purpose  : Shared command, group and state encodings for the search/update
//            scheduler and its drain counter.
// Revision : 1.0 - initial release
// ============================================================================
package search_update_scheduler_pkg;

  // Rule-update command encodings
  localparam logic [1:0] CMD_NOP    = 2'b00;
  localparam logic [1:0] CMD_INSERT = 2'b01;
  localparam logic [1:0] CMD_DELETE = 2'b10;
  localparam logic [1:0] CMD_MODIFY = 2'b11;

  // Group table identifiers (bit position in the one-hot write enable)
  localparam logic [2:0] GRP_G0       = 3'd0;
  localparam logic [2:0] GRP_G1       = 3'd1;
  localparam logic [2:0] GRP_G2       = 3'd2;
  localparam logic [2:0] GRP_G3       = 3'd3;
  localparam logic [2:0] GRP_G4       = 3'd4;
  localparam logic [2:0] GRP_G4_OTHER = 3'd5;

  // Scheduler states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_WRITE = 2'd2
  } state_e;

  // Insert and modify carry entry data; delete writes zeros to clear the valid bit
  function automatic logic cmd_writes_entry(input logic [1:0] cmd);
    return (cmd == CMD_INSERT) || (cmd == CMD_MODIFY);
  endfunction

endpackage
`default_nettype wire

// File: rtl/search_update_scheduler_drain.sv
`default_nettype none
// ============================================================================
// Module   : update_drain_counter
// Purpose  : Counts down the search-pipeline drain before a table write.
//            'last' flags the final drain cycle so the write can be issued
//            on the following edge with registered outputs.
// Revision : 1.0 - initial release
// ============================================================================
module update_drain_counter #(
  parameter int WIDTH      = 3,
  parameter int LOAD_VALUE = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic dec,
  output logic last
);

  logic [WIDTH-1:0] r_count;

  // Load the drain length on update accept, then count down to zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= WIDTH'(LOAD_VALUE);
    end else if (dec && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign last = (r_count == WIDTH'(1));

endmodule
`default_nettype wire

// File: rtl/search_update_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : search_update_scheduler
// Purpose  : Arbitrates the group-table write ports between the packet search
//            stream and rule updates. An accepted update stalls packets,
//            drains the search pipeline, then issues a single-cycle write.
// Revision : 1.0 - initial release
// ============================================================================
module search_update_scheduler
  import search_update_scheduler_pkg::*;
#(
  parameter int INDEX_BIT_LEN   = 11,
  parameter int PACKET_BIT_LEN  = 104,
  parameter int COMMAND_BIT_LEN = 2,
  parameter int ENTRY_BIT_LEN   = 171,
  parameter int GROUP_NUM       = 6,
  parameter int PIPE_DEPTH      = 4,
  parameter int STARVE_LIMIT    = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       pkt_valid,
  output logic                       pkt_ready,
  input  logic [PACKET_BIT_LEN-1:0]  pkt_tuple,
  output logic                       srch_valid,
  output logic [PACKET_BIT_LEN-1:0]  srch_tuple,
  input  logic                       upd_valid,
  output logic                       upd_ready,
  input  logic [COMMAND_BIT_LEN-1:0] upd_cmd,
  input  logic [2:0]                 upd_group,
  input  logic [INDEX_BIT_LEN-1:0]   upd_index,
  input  logic [ENTRY_BIT_LEN-1:0]   upd_entry,
  output logic [GROUP_NUM-1:0]       tbl_we,
  output logic [INDEX_BIT_LEN-1:0]   tbl_addr,
  output logic [ENTRY_BIT_LEN-1:0]   tbl_din,
  output logic                       upd_done,
  output logic                       upd_err,
  output logic                       busy
);

  localparam int c_drain_w  = (PIPE_DEPTH < 1) ? 1 : $clog2(PIPE_DEPTH + 1);
  localparam int c_starve_w = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [c_starve_w-1:0] c_starve_max = c_starve_w'(STARVE_LIMIT);
  localparam logic [GROUP_NUM-1:0]  c_grp_one    = GROUP_NUM'(1);

  state_e                      r_state;
  logic [c_starve_w-1:0]       r_starve_cnt;
  logic [COMMAND_BIT_LEN-1:0]  r_cmd;
  logic [2:0]                  r_group;
  logic [INDEX_BIT_LEN-1:0]    r_index;
  logic [ENTRY_BIT_LEN-1:0]    r_entry;

  logic                        w_take_upd;
  logic                        w_pkt_acc;
  logic                        w_is_nop;
  logic                        w_drain_last;
  logic                        w_issue_wr;
  logic                        w_wr_from_in;
  logic [COMMAND_BIT_LEN-1:0]  w_wr_cmd;
  logic [2:0]                  w_wr_group;
  logic [INDEX_BIT_LEN-1:0]    w_wr_index;
  logic [ENTRY_BIT_LEN-1:0]    w_wr_entry;
  logic                        w_wr_err;

  // Handshakes: update wins only when packets are absent or starvation limit hit
  assign w_take_upd = (r_state == ST_IDLE) && upd_valid &&
                      (!pkt_valid || (r_starve_cnt == c_starve_max));
  assign upd_ready  = w_take_upd;
  assign pkt_ready  = (r_state == ST_IDLE) && !w_take_upd;
  assign w_pkt_acc  = pkt_valid && pkt_ready;
  assign w_is_nop   = (upd_cmd == COMMAND_BIT_LEN'(CMD_NOP));
  assign busy       = (r_state != ST_IDLE);

  // With no pipeline to drain the write goes out straight from the inputs
  assign w_wr_from_in = (r_state == ST_IDLE);
  assign w_wr_cmd     = w_wr_from_in ? upd_cmd   : r_cmd;
  assign w_wr_group   = w_wr_from_in ? upd_group : r_group;
  assign w_wr_index   = w_wr_from_in ? upd_index : r_index;
  assign w_wr_entry   = w_wr_from_in ? upd_entry : r_entry;
  assign w_wr_err     = (int'(w_wr_group) >= GROUP_NUM);
  assign w_issue_wr   = ((r_state == ST_IDLE) && w_take_upd && !w_is_nop && (PIPE_DEPTH == 0)) ||
                        ((r_state == ST_DRAIN) && w_drain_last);

  update_drain_counter #(
    .WIDTH      (c_drain_w),
    .LOAD_VALUE (PIPE_DEPTH)
  ) u_drain (
    .clk  (clk),
    .rst  (rst),
    .load (w_take_upd && !w_is_nop),
    .dec  (r_state == ST_DRAIN),
    .last (w_drain_last)
  );

  // Count packet grants made while an update is waiting; saturates at the limit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_starve_cnt <= '0;
    end else if (!upd_valid || w_take_upd) begin
      r_starve_cnt <= '0;
    end else if (w_pkt_acc && (r_starve_cnt != c_starve_max)) begin
      r_starve_cnt <= r_starve_cnt + 1'b1;
    end
  end

  // Scheduler FSM with registered search issue and table write outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_cmd      <= '0;
      r_group    <= '0;
      r_index    <= '0;
      r_entry    <= '0;
      srch_valid <= 1'b0;
      srch_tuple <= '0;
      tbl_we     <= '0;
      tbl_addr   <= '0;
      tbl_din    <= '0;
      upd_done   <= 1'b0;
      upd_err    <= 1'b0;
    end else begin
      srch_valid <= 1'b0;
      tbl_we     <= '0;
      upd_done   <= 1'b0;
      upd_err    <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (w_pkt_acc) begin
            srch_valid <= 1'b1;
            srch_tuple <= pkt_tuple;
          end
          if (w_take_upd) begin
            r_cmd   <= upd_cmd;
            r_group <= upd_group;
            r_index <= upd_index;
            r_entry <= upd_entry;
            if (w_is_nop) begin
              upd_done <= 1'b1;
            end else if (PIPE_DEPTH == 0) begin
              r_state <= ST_WRITE;
            end else begin
              r_state <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (w_drain_last) begin
            r_state <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase

      if (w_issue_wr) begin
        tbl_we   <= w_wr_err ? '0 : (c_grp_one << w_wr_group);
        tbl_addr <= w_wr_index;
        tbl_din  <= cmd_writes_entry(2'(w_wr_cmd)) ? w_wr_entry : '0;
        upd_done <= 1'b1;
        upd_err  <= w_wr_err;
      end
    end
  end

endmodule
`default_nettype wire
